// File: rtl/spi_pkg.sv
// Shared types for the SPI slave transmit path.
package spi_pkg;

    typedef logic [7:0] spi_byte_t;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        ADVANCE
    } tx_feed_state_t;

    localparam spi_byte_t SPI_FILL_DEFAULT = 8'h00;

endpackage

// File: rtl/byte_fifo_mem.sv
// DEPTH x 8 byte storage: one synchronous write port, one asynchronous read port.
module byte_fifo_mem
    import spi_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  spi_byte_t       wdata_i,
    input  logic [AW-1:0]   raddr_i,
    output spi_byte_t       rdata_o
);

    spi_byte_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/spi_tx_feeder.sv
// Byte FIFO feeding the SPI slave transmit register; advances on each rising send_complete.
// Define SPI_TX_UNDERRUN_CNT_EN to add the saturating underrun_cnt port.
//
// state   | meaning
// IDLE    | FIFO empty, mcu_out shows FILL_BYTE
// HOLD    | at least one byte held, waiting for a send_complete edge
// ADVANCE | one cycle after a pop, mcu_out reloads with the new head
module spi_tx_feeder
    import spi_pkg::*;
#(
    parameter int        DEPTH     = 16,
    parameter spi_byte_t FILL_BYTE = SPI_FILL_DEFAULT,
    localparam int       AW        = $clog2(DEPTH),
    localparam int       CW        = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic          send_complete,
    output logic [7:0]    mcu_out,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          underrun
`ifdef SPI_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]   underrun_cnt
`endif
);

    tx_feed_state_t state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           send_prev_q;
    logic           underrun_q, underrun_d;
    spi_byte_t      mcu_out_q;
    spi_byte_t      head;
    logic           adv, push, pop;

    byte_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign wr_ready = ~full & ~reset;
    assign count    = count_q;
    assign mcu_out  = mcu_out_q;
    assign underrun = underrun_q;

    // HOLD implies count > 0 and IDLE implies count == 0; no edge can occur in
    // ADVANCE because send_prev_q still holds the level that caused the pop.
    always_comb begin
        adv        = send_complete & ~send_prev_q;
        push       = wr_valid & wr_ready;
        pop        = adv & (state_q == HOLD);
        underrun_d = adv & (state_q == IDLE);

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        state_d = state_q;
        case (state_q)
            IDLE:    state_d = push ? HOLD : IDLE;
            HOLD:    state_d = pop ? ADVANCE : HOLD;
            ADVANCE: state_d = (count_d != '0) ? HOLD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            send_prev_q <= 1'b1;
            underrun_q  <= 1'b0;
            mcu_out_q   <= FILL_BYTE;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            send_prev_q <= send_complete;
            underrun_q  <= underrun_d;
            mcu_out_q   <= (count_q != '0) ? head : FILL_BYTE;
        end
    end

`ifdef SPI_TX_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            underrun_cnt_q <= '0;
        end else if (underrun_d && (underrun_cnt_q != 16'hFFFF)) begin
            underrun_cnt_q <= underrun_cnt_q + 16'd1;
        end
    end

    assign underrun_cnt = underrun_cnt_q;
`endif

endmodule

// File: tb/tb_spi_tx_feeder.sv
// Self-checking bench for spi_tx_feeder against a queue-based reference model.
module tb_spi_tx_feeder;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_valid = 1'b0;
    logic       send_complete = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready;
    logic [7:0] mcu_out;
    logic [4:0] count;
    logic       empty, full, underrun;
`ifdef SPI_TX_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
    int          m_ucnt = 0;
`endif

    int total = 0;
    int bad   = 0;

    byte unsigned m_q[$];
    logic         m_prev  = 1'b1;
    logic [7:0]   m_mcu   = 8'h00;
    logic         m_under = 1'b0;

    spi_tx_feeder #(.DEPTH(DEPTH), .FILL_BYTE(8'h00)) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_data       (wr_data),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .send_complete (send_complete),
        .mcu_out       (mcu_out),
        .count         (count),
        .empty         (empty),
        .full          (full),
        .underrun      (underrun)
`ifdef SPI_TX_UNDERRUN_CNT_EN
        ,
        .underrun_cnt  (underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the model over the coming edge, sample after it.
    task automatic step(input logic r, input logic sc, input logic wv, input logic [7:0] wd);
        logic adv;
        logic room;
        @(negedge clk);
        reset = r; send_complete = sc; wr_valid = wv; wr_data = wd;
        if (r) begin
            m_q.delete();
            m_prev = 1'b1; m_mcu = 8'h00; m_under = 1'b0;
`ifdef SPI_TX_UNDERRUN_CNT_EN
            m_ucnt = 0;
`endif
        end else begin
            m_mcu   = (m_q.size() != 0) ? m_q[0] : 8'h00;
            adv     = sc && !m_prev;
            room    = (m_q.size() < DEPTH);
            m_under = adv && (m_q.size() == 0);
`ifdef SPI_TX_UNDERRUN_CNT_EN
            if (m_under && m_ucnt < 65535) m_ucnt++;
`endif
            if (adv && m_q.size() != 0) void'(m_q.pop_front());
            if (wv && room) m_q.push_back(wd);
            m_prev = sc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        total++; if (mcu_out !== 8'h00) begin bad++; $display("FAIL reset_mcu: got %h want 00", mcu_out); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", empty); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", full); end
        total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL reset_wr_ready_hi: got %b want 0", wr_ready); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun: got %b want 0", underrun); end
`ifdef SPI_TX_UNDERRUN_CNT_EN
        total++; if (underrun_cnt !== 16'd0) begin bad++; $display("FAIL reset_ucnt: got %0d want 0", underrun_cnt); end
`endif
        step(0, 0, 0, 8'h00);
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready_lo: got %b want 1", wr_ready); end
    endtask

    task automatic test_basic_feed();
        step(1, 0, 0, 8'h00);
        step(0, 0, 1, 8'h66);
        total++; if (count !== 5'd1) begin bad++; $display("FAIL feed_count1: got %0d want 1", count); end
        total++; if (mcu_out !== 8'h00) begin bad++; $display("FAIL feed_latency: got %h want 00", mcu_out); end
        step(0, 0, 1, 8'h67);
        total++; if (mcu_out !== 8'h66) begin bad++; $display("FAIL feed_first: got %h want 66", mcu_out); end
        step(0, 0, 1, 8'h68);
        step(0, 0, 0, 8'h00);
        total++; if (count !== 5'd3) begin bad++; $display("FAIL feed_count3: got %0d want 3", count); end
        step(0, 1, 0, 8'h00);
        total++; if (count !== 5'd2) begin bad++; $display("FAIL feed_count2: got %0d want 2", count); end
        total++; if (mcu_out !== 8'h66) begin bad++; $display("FAIL feed_hold: got %h want 66", mcu_out); end
        step(0, 0, 0, 8'h00);
        total++; if (mcu_out !== 8'h67) begin bad++; $display("FAIL feed_next: got %h want 67", mcu_out); end
    endtask

    task automatic test_level_held();
        step(1, 0, 0, 8'h00);
        step(0, 0, 1, 8'hA1);
        step(0, 0, 1, 8'hA2);
        step(0, 0, 1, 8'hA3);
        step(0, 0, 0, 8'h00);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 8'h00);
        total++; if (count !== 5'd2) begin bad++; $display("FAIL level_one_pop: got %0d want 2", count); end
        step(0, 0, 0, 8'h00);
        total++; if (mcu_out !== 8'hA2) begin bad++; $display("FAIL level_head: got %h want A2", mcu_out); end
        step(0, 1, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        total++; if (count !== 5'd1) begin bad++; $display("FAIL level_second_pop: got %0d want 1", count); end
        total++; if (mcu_out !== 8'hA3) begin bad++; $display("FAIL level_head2: got %h want A3", mcu_out); end
    endtask

    task automatic test_full_wrap();
        logic [7:0] b;
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 8'(i));
        total++; if (full !== 1'b1) begin bad++; $display("FAIL full_flag: got %b want 1", full); end
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL full_wr_ready: got %b want 0", wr_ready); end
        total++; if (count !== 5'd16) begin bad++; $display("FAIL full_count: got %0d want 16", count); end
        step(0, 1, 1, 8'hEE);
        total++; if (count !== 5'd15) begin bad++; $display("FAIL full_no_bypass: got %0d want 15", count); end
        step(0, 0, 0, 8'h00);
        for (int i = 1; i < 16; i++) begin
            total++; if (mcu_out !== 8'(i)) begin bad++; $display("FAIL drain_order: got %h want %h", mcu_out, 8'(i)); end
            step(0, 1, 0, 8'h00);
            step(0, 0, 0, 8'h00);
        end
        total++; if (empty !== 1'b1 || mcu_out !== 8'h00) begin bad++; $display("FAIL drain_empty: got empty=%b mcu=%h want 1/00", empty, mcu_out); end
        // two refills of 12 then 8 bytes push both pointers past the wrap point
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < (r == 0 ? 12 : 8); i++) step(0, 0, 1, 8'(8'h20 + 8'(r * 16) + 8'(i)));
            step(0, 0, 0, 8'h00);
            for (int i = 0; i < (r == 0 ? 12 : 8); i++) begin
                b = 8'(8'h20 + 8'(r * 16) + 8'(i));
                total++; if (mcu_out !== b) begin bad++; $display("FAIL wrap_order: got %h want %h", mcu_out, b); end
                step(0, 1, 0, 8'h00);
                step(0, 0, 0, 8'h00);
            end
        end
        total++; if (count !== 5'd0) begin bad++; $display("FAIL wrap_count: got %0d want 0", count); end
    endtask

    task automatic test_underrun();
        step(1, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL underrun_pulse: got %b want 1", underrun); end
        total++; if (mcu_out !== 8'h00) begin bad++; $display("FAIL underrun_mcu: got %h want 00", mcu_out); end
`ifdef SPI_TX_UNDERRUN_CNT_EN
        total++; if (underrun_cnt !== 16'd1) begin bad++; $display("FAIL underrun_cnt1: got %0d want 1", underrun_cnt); end
`endif
        step(0, 1, 0, 8'h00);
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL underrun_width: got %b want 0", underrun); end
        step(0, 0, 0, 8'h00);
        step(0, 1, 1, 8'hA5);
        total++; if (underrun !== 1'b1 || count !== 5'd1) begin bad++; $display("FAIL underrun_wr: got u=%b cnt=%0d want 1/1", underrun, count); end
        step(0, 0, 0, 8'h00);
        total++; if (mcu_out !== 8'hA5) begin bad++; $display("FAIL underrun_landed: got %h want A5", mcu_out); end
`ifdef SPI_TX_UNDERRUN_CNT_EN
        total++; if (underrun_cnt !== 16'd2) begin bad++; $display("FAIL underrun_cnt2: got %0d want 2", underrun_cnt); end
`endif
    endtask

    task automatic test_reset_mid();
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 8'(8'hB0 + 8'(i)));
        step(0, 0, 0, 8'h00);
        total++; if (count !== 5'd5) begin bad++; $display("FAIL mid_count5: got %0d want 5", count); end
        step(1, 1, 0, 8'h00);
        total++; if (count !== 5'd0 || mcu_out !== 8'h00) begin bad++; $display("FAIL mid_cleared: got cnt=%0d mcu=%h want 0/00", count, mcu_out); end
        step(0, 1, 1, 8'h3C);
        total++; if (count !== 5'd1 || underrun !== 1'b0) begin bad++; $display("FAIL mid_no_edge: got cnt=%0d u=%b want 1/0", count, underrun); end
        step(0, 1, 0, 8'h00);
        total++; if (count !== 5'd1 || mcu_out !== 8'h3C) begin bad++; $display("FAIL mid_held: got cnt=%0d mcu=%h want 1/3C", count, mcu_out); end
    endtask

    task automatic test_random();
        logic sc;
        logic wv;
        sc = 1'b0;
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 2) == 0) sc = ~sc;
            wv = ($urandom_range(0, 99) < ((i % 200) < 100 ? 75 : 20));
            step(($urandom_range(0, 149) == 0), sc, wv, 8'($urandom));
            total++; if (mcu_out !== m_mcu) begin bad++; $display("FAIL rnd_mcu: cyc %0d got %h want %h", i, mcu_out, m_mcu); end
            total++; if (count !== 5'(m_q.size())) begin bad++; $display("FAIL rnd_count: cyc %0d got %0d want %0d", i, count, m_q.size()); end
            total++; if (empty !== (m_q.size() == 0)) begin bad++; $display("FAIL rnd_empty: cyc %0d got %b", i, empty); end
            total++; if (full !== (m_q.size() == DEPTH)) begin bad++; $display("FAIL rnd_full: cyc %0d got %b", i, full); end
            total++; if (underrun !== m_under) begin bad++; $display("FAIL rnd_underrun: cyc %0d got %b want %b", i, underrun, m_under); end
            total++; if (wr_ready !== ((m_q.size() < DEPTH) && !reset)) begin bad++; $display("FAIL rnd_wr_ready: cyc %0d got %b", i, wr_ready); end
`ifdef SPI_TX_UNDERRUN_CNT_EN
            total++; if (underrun_cnt !== 16'(m_ucnt)) begin bad++; $display("FAIL rnd_ucnt: cyc %0d got %0d want %0d", i, underrun_cnt, m_ucnt); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic_feed();
        test_level_held();
        test_full_wrap();
        test_underrun();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
